// File: rtl/conv_layer_scheduler.sv
// Conv layer job scheduler: streams weights into each target BRAM,
// then holds compute enable until the requested frame count is reached.
module conv_layer_scheduler #(
  parameter int NUM_TARGETS      = 5,
  parameter int BEATS_PER_TARGET = 144,
  parameter int AXIS_DATA_WIDTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cfg_start,
  input  logic                       i_cfg_reload,
  input  logic [15:0]                i_cfg_num_frames,
  input  logic [8:0]                 i_cfg_l1_base,
  input  logic [8:0]                 i_cfg_l2_base,
  input  logic                       i_abort,
  input  logic                       s_axis_w_tvalid,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_w_tdata,
  input  logic                       s_axis_w_tlast,
  output logic                       s_axis_w_tready,
  output logic                       m_axis_w_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_w_tdata,
  output logic                       m_axis_w_tlast,
  input  logic                       m_axis_w_tready,
  output logic                       o_load_weights,
  output logic [3:0]                 o_target_layer,
  output logic                       o_start_compute,
  output logic [8:0]                 o_l1_weight_base,
  output logic [8:0]                 o_l2_weight_base,
  input  logic                       i_compute_done,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [15:0]                o_frame_cnt,
  output logic                       o_err
);

  localparam int TW =
    (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  localparam logic [TW-1:0] T_LAST =
    TW'(NUM_TARGETS - 1);
  localparam logic [15:0] B_LAST =
    16'(BEATS_PER_TARGET - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_RST  = 3'd1;
  localparam logic [2:0] S_LOAD_DATA = 3'd2;
  localparam logic [2:0] S_COMPUTE   = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] tgt;
  logic [15:0]   beat_cnt;
  logic [15:0]   num_frames;
  logic [15:0]   frame_inc;
  logic          in_load;
  logic          in_data;
  logic          beat;
  logic          beat_final;
  logic          start_ok;
  logic          abort_ok;

  assign in_data = (state == S_LOAD_DATA);
  assign in_load = in_data || (state == S_LOAD_RST);

  assign m_axis_w_tvalid = in_data && s_axis_w_tvalid;
  assign s_axis_w_tready = in_data && m_axis_w_tready;
  assign m_axis_w_tdata  = s_axis_w_tdata;
  assign m_axis_w_tlast  = s_axis_w_tlast;

  assign o_target_layer = in_load ? 4'(tgt) : 4'd0;

  assign beat       = in_data && s_axis_w_tvalid
                   && m_axis_w_tready;
  assign beat_final = beat && (beat_cnt == B_LAST);
  assign start_ok   = (state == S_IDLE) && i_cfg_start;
  assign abort_ok   = (state != S_IDLE) && i_abort;

  assign frame_inc = (o_frame_cnt == 16'hFFFF) ?
    o_frame_cnt : o_frame_cnt + 16'd1;

  always_comb begin
    state_nxt = state;
    if (abort_ok) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cfg_start)
            state_nxt = i_cfg_reload ?
              S_LOAD_RST : S_COMPUTE;
        end
        S_LOAD_RST: state_nxt = S_LOAD_DATA;
        S_LOAD_DATA: begin
          if (beat_final)
            state_nxt = (tgt == T_LAST) ?
              S_COMPUTE : S_LOAD_RST;
        end
        S_COMPUTE: begin
          if (num_frames == 16'd0)
            state_nxt = S_DONE;
          else if (i_compute_done
                   && frame_inc == num_frames)
            state_nxt = S_DONE;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control outputs follow the next state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      tgt              <= '0;
      beat_cnt         <= '0;
      num_frames       <= '0;
      o_frame_cnt      <= '0;
      o_err            <= 1'b0;
      o_l1_weight_base <= '0;
      o_l2_weight_base <= '0;
      o_load_weights   <= 1'b0;
      o_start_compute  <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      state           <= state_nxt;
      o_load_weights  <= (state_nxt == S_LOAD_RST);
      o_start_compute <= (state_nxt == S_COMPUTE);
      o_busy          <= (state_nxt != S_IDLE);
      o_done          <= (state_nxt == S_DONE);

      if (start_ok) begin
        num_frames       <= i_cfg_num_frames;
        o_l1_weight_base <= i_cfg_l1_base;
        o_l2_weight_base <= i_cfg_l2_base;
        o_frame_cnt      <= '0;
        o_err            <= 1'b0;
        tgt              <= '0;
        beat_cnt         <= '0;
      end else if (!abort_ok) begin
        if (state == S_LOAD_RST)
          beat_cnt <= '0;

        if (beat) begin
          if (s_axis_w_tlast != beat_final)
            o_err <= 1'b1;
          if (beat_final) begin
            beat_cnt <= '0;
            if (tgt != T_LAST)
              tgt <= tgt + 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 16'd1;
          end
        end

        if (state == S_COMPUTE && i_compute_done
            && num_frames != 16'd0)
          o_frame_cnt <= frame_inc;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: load, compute,
// tlast errors, abort, ignored starts and mid-job reset.
module tb_conv_layer_scheduler;

  logic        clk;
  logic        rst;
  logic        i_cfg_start;
  logic        i_cfg_reload;
  logic [15:0] i_cfg_num_frames;
  logic [8:0]  i_cfg_l1_base;
  logic [8:0]  i_cfg_l2_base;
  logic        i_abort;
  logic        s_axis_w_tvalid;
  logic [63:0] s_axis_w_tdata;
  logic        s_axis_w_tlast;
  logic        s_axis_w_tready;
  logic        m_axis_w_tvalid;
  logic [63:0] m_axis_w_tdata;
  logic        m_axis_w_tlast;
  logic        m_axis_w_tready;
  logic        o_load_weights;
  logic [3:0]  o_target_layer;
  logic        o_start_compute;
  logic [8:0]  o_l1_weight_base;
  logic [8:0]  o_l2_weight_base;
  logic        i_compute_done;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_frame_cnt;
  logic        o_err;

  conv_layer_scheduler #(
    .NUM_TARGETS(5),
    .BEATS_PER_TARGET(4),
    .AXIS_DATA_WIDTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_cfg_start(i_cfg_start),
    .i_cfg_reload(i_cfg_reload),
    .i_cfg_num_frames(i_cfg_num_frames),
    .i_cfg_l1_base(i_cfg_l1_base),
    .i_cfg_l2_base(i_cfg_l2_base),
    .i_abort(i_abort),
    .s_axis_w_tvalid(s_axis_w_tvalid),
    .s_axis_w_tdata(s_axis_w_tdata),
    .s_axis_w_tlast(s_axis_w_tlast),
    .s_axis_w_tready(s_axis_w_tready),
    .m_axis_w_tvalid(m_axis_w_tvalid),
    .m_axis_w_tdata(m_axis_w_tdata),
    .m_axis_w_tlast(m_axis_w_tlast),
    .m_axis_w_tready(m_axis_w_tready),
    .o_load_weights(o_load_weights),
    .o_target_layer(o_target_layer),
    .o_start_compute(o_start_compute),
    .o_l1_weight_base(o_l1_weight_base),
    .o_l2_weight_base(o_l2_weight_base),
    .i_compute_done(i_compute_done),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_frame_cnt(o_frame_cnt),
    .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_load = 0;
  int n_done = 0;
  int n_fwd = 0;
  int data_bad = 0;
  logic [3:0] tgt_log [0:63];

  always @(negedge clk) begin
    if (!rst) begin
      if (o_load_weights && n_load < 64) begin
        tgt_log[n_load] = o_target_layer;
        n_load++;
      end
      if (o_done)
        n_done++;
      if (m_axis_w_tvalid && m_axis_w_tready)
        n_fwd++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic rl,
                           input logic [15:0] nf,
                           input logic [8:0] b1,
                           input logic [8:0] b2);
    i_cfg_reload     = rl;
    i_cfg_num_frames = nf;
    i_cfg_l1_base    = b1;
    i_cfg_l2_base    = b2;
    i_cfg_start      = 1'b1;
    tick();
    i_cfg_start      = 1'b0;
  endtask

  task automatic pulse_done();
    i_compute_done = 1'b1;
    tick();
    i_compute_done = 1'b0;
  endtask

  // Drives beats 0..nbeats-1; tlast on every 4th beat
  // plus the optional corrupted index.
  task automatic run_load(input bit toggle,
                          input int bad,
                          input int nbeats);
    int sent;
    int cyc;
    bit acc;
    sent = 0;
    cyc  = 0;
    while (sent < nbeats && cyc < 500) begin
      m_axis_w_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      s_axis_w_tvalid = 1'b1;
      s_axis_w_tdata  = 64'hA500_0000_0000_0000
                      | 64'(sent);
      s_axis_w_tlast  = (sent % 4 == 3) || (sent == bad);
      @(negedge clk);
      acc = s_axis_w_tready && s_axis_w_tvalid;
      if (m_axis_w_tvalid
          && (m_axis_w_tdata != s_axis_w_tdata
              || m_axis_w_tlast != s_axis_w_tlast))
        data_bad++;
      tick();
      if (acc)
        sent++;
      cyc++;
    end
    s_axis_w_tvalid = 1'b0;
    s_axis_w_tlast  = 1'b0;
    m_axis_w_tready = 1'b1;
    chk("load_beats", 64'(sent), 64'(nbeats));
  endtask

  int l0, d0, f0;

  initial begin
    rst              = 1'b1;
    i_cfg_start      = 1'b0;
    i_cfg_reload     = 1'b0;
    i_cfg_num_frames = '0;
    i_cfg_l1_base    = '0;
    i_cfg_l2_base    = '0;
    i_abort          = 1'b0;
    i_compute_done   = 1'b0;
    s_axis_w_tvalid  = 1'b1;
    s_axis_w_tdata   = '0;
    s_axis_w_tlast   = 1'b0;
    m_axis_w_tready  = 1'b1;
    repeat (3) tick();

    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_load", o_load_weights, 0);
    chk("rst_comp", o_start_compute, 0);
    chk("rst_err", o_err, 0);
    chk("rst_frames", o_frame_cnt, 0);
    chk("rst_l1", o_l1_weight_base, 0);
    chk("rst_l2", o_l2_weight_base, 0);
    chk("rst_tready", s_axis_w_tready, 0);
    chk("rst_tvalid", m_axis_w_tvalid, 0);
    chk("rst_tgt", o_target_layer, 0);
    rst = 1'b0;
    s_axis_w_tvalid = 1'b0;
    tick();

    // Full reload job, two frames
    l0 = n_load; d0 = n_done; f0 = n_fwd;
    start_job(1'b1, 16'd2, 9'h055, 9'h0AA);
    chk("a_busy", o_busy, 1);
    chk("a_loadpulse", o_load_weights, 1);
    run_load(1'b0, -1, 20);
    chk("a_nload", 64'(n_load - l0), 5);
    for (int i = 0; i < 5; i++)
      chk("a_tgt", tgt_log[l0 + i], 64'(i));
    chk("a_nfwd", 64'(n_fwd - f0), 20);
    chk("a_data", 64'(data_bad), 0);
    chk("a_comp", o_start_compute, 1);
    chk("a_tgt_idle", o_target_layer, 0);
    chk("a_tready", s_axis_w_tready, 0);
    pulse_done();
    chk("a_frame1", o_frame_cnt, 1);
    chk("a_comp1", o_start_compute, 1);
    tick();
    pulse_done();
    chk("a_frame2", o_frame_cnt, 2);
    chk("a_done", o_done, 1);
    chk("a_comp_off", o_start_compute, 0);
    chk("a_err", o_err, 0);
    chk("a_l1", o_l1_weight_base, 9'h055);
    chk("a_l2", o_l2_weight_base, 9'h0AA);
    tick();
    chk("a_done_off", o_done, 0);
    chk("a_idle", o_busy, 0);
    chk("a_ndone", 64'(n_done - d0), 1);

    // Throttled load with a bad tlast, start ignored in compute
    l0 = n_load; d0 = n_done; f0 = n_fwd;
    start_job(1'b1, 16'd1, 9'h123, 9'h0F0);
    run_load(1'b1, 5, 20);
    chk("b_nload", 64'(n_load - l0), 5);
    chk("b_nfwd", 64'(n_fwd - f0), 20);
    chk("b_err", o_err, 1);
    chk("b_comp", o_start_compute, 1);
    start_job(1'b0, 16'd7, 9'h1FF, 9'h1FF);
    chk("b_ign_l1", o_l1_weight_base, 9'h123);
    chk("b_ign_l2", o_l2_weight_base, 9'h0F0);
    chk("b_ign_comp", o_start_compute, 1);
    pulse_done();
    chk("b_done", o_done, 1);
    chk("b_frame", o_frame_cnt, 1);
    tick();
    chk("b_err_sticky", o_err, 1);
    pulse_done();
    chk("b_idle_cdone", o_frame_cnt, 1);
    chk("b_ndone", 64'(n_done - d0), 1);

    // Compute-only, zero frames
    l0 = n_load;
    start_job(1'b0, 16'd0, 9'h010, 9'h1A0);
    chk("c_err_clr", o_err, 0);
    chk("c_frame_clr", o_frame_cnt, 0);
    chk("c_comp", o_start_compute, 1);
    chk("c_l1", o_l1_weight_base, 9'h010);
    chk("c_l2", o_l2_weight_base, 9'h1A0);
    tick();
    chk("c_done", o_done, 1);
    chk("c_nload", 64'(n_load - l0), 0);
    tick();

    // Abort in LOAD_DATA of target 3
    d0 = n_done;
    start_job(1'b1, 16'd1, 9'h001, 9'h002);
    run_load(1'b0, -1, 13);
    s_axis_w_tvalid = 1'b1;
    i_abort = 1'b1;
    #1;
    chk("d_tgt3", o_target_layer, 3);
    tick();
    i_abort = 1'b0;
    chk("d_busy", o_busy, 0);
    chk("d_tready", s_axis_w_tready, 0);
    chk("d_tvalid", m_axis_w_tvalid, 0);
    chk("d_load", o_load_weights, 0);
    s_axis_w_tvalid = 1'b0;
    repeat (2) tick();
    chk("d_ndone", 64'(n_done - d0), 0);

    l0 = n_load; d0 = n_done;
    start_job(1'b1, 16'd1, 9'h003, 9'h004);
    chk("d_restart_tgt", o_target_layer, 0);
    run_load(1'b0, -1, 20);
    chk("d_nload", 64'(n_load - l0), 5);
    chk("d_first_tgt", tgt_log[l0], 0);
    chk("d_last_tgt", tgt_log[l0 + 4], 4);
    pulse_done();
    chk("d_done", o_done, 1);
    tick();

    // Abort in COMPUTE keeps the frame count
    d0 = n_done;
    start_job(1'b0, 16'd3, 9'h005, 9'h006);
    pulse_done();
    i_abort = 1'b1;
    i_compute_done = 1'b1;
    tick();
    i_abort = 1'b0;
    i_compute_done = 1'b0;
    chk("e_busy", o_busy, 0);
    chk("e_comp", o_start_compute, 0);
    chk("e_frame", o_frame_cnt, 1);
    repeat (2) tick();
    chk("e_ndone", 64'(n_done - d0), 0);

    // Reset mid-load
    d0 = n_done;
    start_job(1'b1, 16'd2, 9'h0AB, 9'h0CD);
    run_load(1'b0, 1, 6);
    rst = 1'b1;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("r_busy", o_busy, 0);
    chk("r_load", o_load_weights, 0);
    chk("r_err", o_err, 0);
    chk("r_l1", o_l1_weight_base, 0);
    chk("r_tready", s_axis_w_tready, 0);
    rst = 1'b0;
    repeat (2) tick();
    chk("r_ndone", 64'(n_done - d0), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 Parameter NUM_TARGETS, default 5, number of weight-BRAM targets loaded in order 0..NUM_TARGETS-1 (0-3 layer-1 cores, 4 layer-2).
REQ-002 Parameter BEATS_PER_TARGET, default 144, 64-bit weight beats per target; legal range 1..65535.
REQ-003 Parameter AXIS_DATA_WIDTH, default 64, weight stream width.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_cfg_start  in  1  one-cycle job start request.
REQ-007 i_cfg_reload  in  1  1 = load weights before computing; 0 = compute only; sampled with i_cfg_start.
REQ-008 i_cfg_num_frames  in  16  frames to compute; sampled with i_cfg_start.
REQ-009 i_cfg_l1_base, i_cfg_l2_base  in  9 each  weight read bases; sampled with i_cfg_start.
REQ-010 i_abort  in  1  abort current job.
REQ-011 s_axis_w_tvalid/tdata/tlast  in  1/64/1  weight stream from DMA; s_axis_w_tready  out  1.
REQ-012 m_axis_w_tvalid/tdata/tlast  out  1/64/1  weight stream to datapath; m_axis_w_tready  in  1.
REQ-013 o_load_weights  out  1; o_target_layer  out  4; o_start_compute  out  1; o_l1_weight_base, o_l2_weight_base  out  9 each.
REQ-014 i_compute_done  in  1  one-cycle end-of-frame pulse from datapath.
REQ-015 o_busy  out  1; o_done  out  1 (one-cycle pulse); o_frame_cnt  out  16; o_err  out  1 (sticky).

Function
REQ-016 States: IDLE, LOAD_RST, LOAD_DATA, COMPUTE, DONE.
REQ-017 IDLE: i_cfg_start=1 latches all cfg inputs, clears o_frame_cnt and o_err; next LOAD_RST if reload=1 else COMPUTE; target counter t=0.
REQ-018 i_cfg_start outside IDLE is ignored.
REQ-019 LOAD_RST: exactly one cycle; o_load_weights=1, o_target_layer=t; beat counter cleared; next LOAD_DATA.
REQ-020 LOAD_DATA: m_axis_w_tvalid=s_axis_w_tvalid, s_axis_w_tready=m_axis_w_tready, tdata/tlast passed combinationally; outside LOAD_DATA both tvalid and tready = 0.
REQ-021 Beat counted only on s_axis_w_tvalid & m_axis_w_tready; on beat BEATS_PER_TARGET of target t: if t<NUM_TARGETS-1, t++ and next LOAD_RST; else next COMPUTE.
REQ-022 o_err set if tlast=1 on a non-final beat of a target or tlast=0 on the final beat; beat counting continues regardless.
REQ-023 o_target_layer holds t in LOAD_RST and LOAD_DATA; 0 elsewhere.
REQ-024 COMPUTE: o_start_compute=1 continuously; each i_compute_done pulse increments o_frame_cnt; when incremented value equals num_frames, next DONE and o_start_compute drops the following cycle.
REQ-025 num_frames=0: COMPUTE exits to DONE after one cycle, no frames counted.
REQ-026 i_compute_done outside COMPUTE ignored.
REQ-027 DONE: o_done=1 one cycle; next IDLE.
REQ-028 o_busy=1 in every state except IDLE.
REQ-029 o_l1/o_l2_weight_base output the latched values and change only on an accepted i_cfg_start.
REQ-030 i_abort=1 in any non-IDLE state: next state IDLE, no o_done, all stream/handshake outputs 0 from the next cycle; o_frame_cnt and o_err retain values. i_abort has priority over i_compute_done and beat completion in the same cycle.
REQ-031 o_frame_cnt saturates at 65535.
REQ-032 All control outputs (o_load_weights, o_start_compute, o_busy, o_done) registered; stream pass-through is the only combinational path.

Reset
REQ-033 rst=1: state IDLE; t, beat counter, o_frame_cnt = 0; o_load_weights, o_start_compute, o_busy, o_done, o_err = 0; base outputs = 0; m_axis_w_tvalid, s_axis_w_tready = 0.
REQ-034 rst mid-job overrides i_abort and all inputs; no partial o_done.

Verification
REQ-035 NUM_TARGETS=5, BEATS=4, reload=1, frames=2, tlast on every 4th beat -> five o_load_weights pulses with o_target_layer 0..4, 20 beats forwarded, then o_start_compute=1; two done pulses -> o_frame_cnt=2, o_done pulse, o_err=0.
REQ-036 m_axis_w_tready toggled 1/0 every cycle during load -> beats counted only on handshake; still exactly 4 beats per target.
REQ-037 tlast asserted on beat 2 of target 1 -> o_err=1 sticky; load completes normally; cleared only by next accepted i_cfg_start.
REQ-038 reload=0, frames=0, bases 0x10/0x1A0 -> no load pulses, DONE two cycles after start, bases output 0x010/0x1A0.
REQ-039 i_abort during LOAD_DATA of target 3 -> IDLE next cycle, tready=0, no o_done; new i_cfg_start restarts at target 0.
REQ-040 i_cfg_start pulsed while in COMPUTE -> ignored, latched config unchanged.
